// File: rtl/magphase_share_arb_pkg.sv
// rtl/magphase_share_arb_pkg.sv - shared state encodings and defaults for the magphase core arbiter
package magphase_share_arb_pkg;

  localparam int WIDTH_DEFAULT     = 32;
  localparam int TAG_DEPTH_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_t;

  // One-hot input owner for a given arbiter state; idle reports no owner.
  function automatic logic [1:0] state_owner(input arb_state_t s);
    logic [1:0] oh;
    case (s)
      ST_GRANT0: oh = 2'b01;
      ST_GRANT1: oh = 2'b10;
      default:   oh = 2'b00;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/magphase_arb_tag_fifo.sv
// rtl/magphase_arb_tag_fifo.sv - in-order 1-bit owner tag FIFO with registered head
module magphase_arb_tag_fifo
  import magphase_share_arb_pkg::*;
#(
  parameter int TAG_DEPTH = TAG_DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               push_tag,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [TAG_DEPTH:0] count,
  output logic               head
);

  localparam int DEPTH = 1 << TAG_DEPTH;

  logic [DEPTH-1:0]     mem;
  logic [TAG_DEPTH-1:0] wr_ptr;
  logic [TAG_DEPTH-1:0] rd_ptr;
  logic [TAG_DEPTH-1:0] rd_next;
  logic [TAG_DEPTH:0]   cnt;
  logic                 head_q;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (cnt == (TAG_DEPTH+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = head_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_next = rd_ptr + 1'b1;

  // Tag storage needs no reset; only slots between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_tag;
    end
  end

  // Pointers, occupancy and the registered head tag. The head bypasses storage when
  // the pushed tag becomes the oldest entry in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_next;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push_ok && (empty || (pop_ok && cnt == (TAG_DEPTH+1)'(1)))) begin
        head_q <= push_tag;
      end else if (pop_ok) begin
        head_q <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/magphase_share_arb.sv
// rtl/magphase_share_arb.sv - packet round-robin sharing of one magphase core between two requesters
module magphase_share_arb
  import magphase_share_arb_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int TAG_DEPTH = TAG_DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         port_en,
  input  logic [WIDTH-1:0]   i0_tdata,
  input  logic               i0_tlast,
  input  logic               i0_tvalid,
  output logic               i0_tready,
  input  logic [WIDTH-1:0]   i1_tdata,
  input  logic               i1_tlast,
  input  logic               i1_tvalid,
  output logic               i1_tready,
  output logic [WIDTH-1:0]   o0_tdata,
  output logic               o0_tlast,
  output logic               o0_tvalid,
  input  logic               o0_tready,
  output logic [WIDTH-1:0]   o1_tdata,
  output logic               o1_tlast,
  output logic               o1_tvalid,
  input  logic               o1_tready,
  output logic [WIDTH-1:0]   core_in_tdata,
  output logic               core_in_tlast,
  output logic               core_in_tvalid,
  input  logic               core_in_tready,
  input  logic [WIDTH-1:0]   core_out_tdata,
  input  logic               core_out_tlast,
  input  logic               core_out_tvalid,
  output logic               core_out_tready,
  output logic [1:0]         owner,
  output logic [TAG_DEPTH:0] inflight,
  output logic               err_orphan
);

  arb_state_t         state;
  arb_state_t         state_next;
  logic               last_grant;
  logic               tag_push;
  logic               tag_in;
  logic               tag_pop;
  logic               tag_full;
  logic               tag_empty;
  logic               tag_head;
  logic [TAG_DEPTH:0] tag_count;
  logic               elig0;
  logic               elig1;

  magphase_arb_tag_fifo #(
    .TAG_DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (tag_push),
    .push_tag (tag_in),
    .pop      (tag_pop),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (tag_count),
    .head     (tag_head)
  );

  // A new packet may only start while a tag slot is free, so the return path can always route it.
  assign elig0    = i0_tvalid & port_en[0] & ~tag_full;
  assign elig1    = i1_tvalid & port_en[1] & ~tag_full;
  assign owner    = state_owner(state);
  assign inflight = tag_count;

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Remembers the most recent grant; starts at port 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (tag_push) begin
      last_grant <= tag_in;
    end
  end

  // Grant selection and forward mux; port_en is only consulted when a packet starts.
  always_comb begin
    state_next     = state;
    tag_push       = 1'b0;
    tag_in         = 1'b0;
    i0_tready      = 1'b0;
    i1_tready      = 1'b0;
    core_in_tdata  = '0;
    core_in_tlast  = 1'b0;
    core_in_tvalid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (elig0 && (!elig1 || last_grant)) begin
          state_next = ST_GRANT0;
          tag_push   = 1'b1;
          tag_in     = 1'b0;
        end else if (elig1) begin
          state_next = ST_GRANT1;
          tag_push   = 1'b1;
          tag_in     = 1'b1;
        end
      end
      ST_GRANT0: begin
        core_in_tdata  = i0_tdata;
        core_in_tlast  = i0_tlast;
        core_in_tvalid = i0_tvalid;
        i0_tready      = core_in_tready;
        if (i0_tvalid && core_in_tready && i0_tlast) begin
          state_next = ST_IDLE;
        end
      end
      ST_GRANT1: begin
        core_in_tdata  = i1_tdata;
        core_in_tlast  = i1_tlast;
        core_in_tvalid = i1_tvalid;
        i1_tready      = core_in_tready;
        if (i1_tvalid && core_in_tready && i1_tlast) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o0_tdata = core_out_tdata;
  assign o0_tlast = core_out_tlast;
  assign o1_tdata = core_out_tdata;
  assign o1_tlast = core_out_tlast;

  // Return routing by the oldest outstanding tag; with no tag the core output is refused.
  always_comb begin
    o0_tvalid       = 1'b0;
    o1_tvalid       = 1'b0;
    core_out_tready = 1'b0;
    if (!tag_empty) begin
      if (tag_head) begin
        o1_tvalid       = core_out_tvalid;
        core_out_tready = o1_tready;
      end else begin
        o0_tvalid       = core_out_tvalid;
        core_out_tready = o0_tready;
      end
    end
  end

  assign tag_pop = core_out_tvalid & core_out_tready & core_out_tlast;

  // Sticky flag for core output that no granted packet accounts for.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_orphan <= 1'b0;
    end else if (tag_empty && core_out_tvalid) begin
      err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_magphase_share_arb.sv
// tb/tb_magphase_share_arb.sv - scoreboard bench for the shared magphase core arbiter
module tb_magphase_share_arb;

  localparam int WIDTH     = 32;
  localparam int TAG_DEPTH = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [1:0]         port_en = 2'b11;
  logic [WIDTH-1:0]   i0_tdata = '0, i1_tdata = '0;
  logic               i0_tlast = 1'b0, i0_tvalid = 1'b0, i0_tready;
  logic               i1_tlast = 1'b0, i1_tvalid = 1'b0, i1_tready;
  logic [WIDTH-1:0]   o0_tdata, o1_tdata;
  logic               o0_tlast, o0_tvalid, o0_tready = 1'b0;
  logic               o1_tlast, o1_tvalid, o1_tready = 1'b0;
  logic [WIDTH-1:0]   core_in_tdata;
  logic               core_in_tlast, core_in_tvalid, core_in_tready = 1'b0;
  logic [WIDTH-1:0]   core_out_tdata = '0;
  logic               core_out_tlast = 1'b0, core_out_tvalid = 1'b0, core_out_tready;
  logic [1:0]         owner;
  logic [TAG_DEPTH:0] inflight;
  logic               err_orphan;

  magphase_share_arb #(.WIDTH(WIDTH), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .reset(reset), .port_en(port_en),
    .i0_tdata(i0_tdata), .i0_tlast(i0_tlast), .i0_tvalid(i0_tvalid), .i0_tready(i0_tready),
    .i1_tdata(i1_tdata), .i1_tlast(i1_tlast), .i1_tvalid(i1_tvalid), .i1_tready(i1_tready),
    .o0_tdata(o0_tdata), .o0_tlast(o0_tlast), .o0_tvalid(o0_tvalid), .o0_tready(o0_tready),
    .o1_tdata(o1_tdata), .o1_tlast(o1_tlast), .o1_tvalid(o1_tvalid), .o1_tready(o1_tready),
    .core_in_tdata(core_in_tdata), .core_in_tlast(core_in_tlast),
    .core_in_tvalid(core_in_tvalid), .core_in_tready(core_in_tready),
    .core_out_tdata(core_out_tdata), .core_out_tlast(core_out_tlast),
    .core_out_tvalid(core_out_tvalid), .core_out_tready(core_out_tready),
    .owner(owner), .inflight(inflight), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct { logic [WIDTH-1:0] data; logic last; } beat_t;
  typedef struct { logic [WIDTH-1:0] data; logic last; int port; longint due; } core_beat_t;

  beat_t      in_q0[$], in_q1[$], exp_q0[$], exp_q1[$];
  core_beat_t core_q[$];
  int         gq_port[$];
  longint     gq_cyc[$];
  int         oq_port[$];
  int         vectors = 0, miscompares = 0;
  longint     cyc = 0;
  int         vld_pct = 100, rdy0_pct = 100, rdy1_pct = 100, cin_pct = 100;
  int         lat_min = 1, lat_max = 1;
  bit         core_auto = 1'b1;
  bit         v0 = 0, v1 = 0, f_i0 = 0, f_i1 = 0, f_cout = 0;
  int         o0_beats = 0, o1_beats = 0;
  logic [1:0] prev_owner = 2'b00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input int port, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      b.last = (i == len - 1);
      if (port == 0) in_q0.push_back(b);
      else           in_q1.push_back(b);
    end
  endtask

  // Environment driver: requesters, output sinks and an identity core with random latency.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (f_cout) begin
        if (core_q.size() > 0) void'(core_q.pop_front());
        f_cout = 0;
      end
      if (f_i0 || in_q0.size() == 0) v0 = 0;
      if (!v0 && in_q0.size() > 0 && $urandom_range(99) < vld_pct) v0 = 1;
      if (f_i1 || in_q1.size() == 0) v1 = 0;
      if (!v1 && in_q1.size() > 0 && $urandom_range(99) < vld_pct) v1 = 1;
      f_i0 = 0;
      f_i1 = 0;
      i0_tvalid = v0;
      i0_tdata  = v0 ? in_q0[0].data : '0;
      i0_tlast  = v0 ? in_q0[0].last : 1'b0;
      i1_tvalid = v1;
      i1_tdata  = v1 ? in_q1[0].data : '0;
      i1_tlast  = v1 ? in_q1[0].last : 1'b0;
      o0_tready      = ($urandom_range(99) < rdy0_pct);
      o1_tready      = ($urandom_range(99) < rdy1_pct);
      core_in_tready = ($urandom_range(99) < cin_pct);
      if (core_auto) begin
        if (core_q.size() > 0 && core_q[0].due <= cyc) begin
          core_out_tvalid = 1'b1;
          core_out_tdata  = core_q[0].data;
          core_out_tlast  = core_q[0].last;
        end else begin
          core_out_tvalid = 1'b0;
          core_out_tdata  = '0;
          core_out_tlast  = 1'b0;
        end
      end
    end
  end

  // Stimulus side of the scoreboard: accepted input beats become expected results.
  initial begin
    beat_t      b;
    core_beat_t c;
    forever begin
      @(negedge clk);
      c.port = 2;
      if (i0_tvalid && i0_tready && in_q0.size() > 0) begin
        b = in_q0.pop_front();
        exp_q0.push_back(b);
        f_i0 = 1;
        c.port = 0;
      end
      if (i1_tvalid && i1_tready && in_q1.size() > 0) begin
        b = in_q1.pop_front();
        exp_q1.push_back(b);
        f_i1 = 1;
        c.port = 1;
      end
      if (core_in_tvalid && core_in_tready) begin
        c.data = core_in_tdata;
        c.last = core_in_tlast;
        c.due  = cyc + longint'($urandom_range(lat_max, lat_min));
        if (core_q.size() > 0 && c.due < core_q[$].due) c.due = core_q[$].due;
        core_q.push_back(c);
      end
      if (core_auto && core_out_tvalid && core_out_tready) f_cout = 1;
    end
  end

  // Monitor: logs grants, checks return routing and pops the scoreboard on output beats.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (owner != prev_owner && owner != 2'b00) begin
        gq_port.push_back(owner == 2'b10 ? 1 : 0);
        gq_cyc.push_back(cyc);
      end
      prev_owner = owner;
      if (core_auto && core_out_tvalid && core_q.size() > 0) begin
        chk("route_valid", {o1_tvalid, o0_tvalid}, core_q[0].port == 0 ? 2'b01 : 2'b10);
        chk("core_out_tready", core_out_tready, core_q[0].port == 0 ? o0_tready : o1_tready);
      end
      if (o0_tvalid && o0_tready) begin
        o0_beats++;
        if (exp_q0.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL o0_unexpected: beat %h with no pending port0 input", o0_tdata);
        end else begin
          e = exp_q0.pop_front();
          chk("o0_data", o0_tdata, e.data);
          chk("o0_last", o0_tlast, e.last);
        end
        if (o0_tlast) oq_port.push_back(0);
      end
      if (o1_tvalid && o1_tready) begin
        o1_beats++;
        if (exp_q1.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL o1_unexpected: beat %h with no pending port1 input", o1_tdata);
        end else begin
          e = exp_q1.pop_front();
          chk("o1_data", o1_tdata, e.data);
          chk("o1_last", o1_tlast, e.last);
        end
        if (o1_tlast) oq_port.push_back(1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    i0_tvalid = 1'b0; i1_tvalid = 1'b0; core_out_tvalid = 1'b0;
    v0 = 0; v1 = 0; f_i0 = 0; f_i1 = 0; f_cout = 0;
    in_q0.delete(); in_q1.delete(); exp_q0.delete(); exp_q1.delete(); core_q.delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
    gq_port.delete(); gq_cyc.delete(); oq_port.delete();
    o0_beats = 0; o1_beats = 0;
  endtask

  task automatic wait_owner(input string name, input logic [1:0] want, input int max);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (owner == want) seen = 1;
    end
    chk(name, seen, 1);
  endtask

  task automatic wait_drain(input string name, input int max);
    bit done = 0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      if (in_q0.size() == 0 && in_q1.size() == 0 && exp_q0.size() == 0 &&
          exp_q1.size() == 0 && core_q.size() == 0) done = 1;
    end
    chk(name, done, 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic knobs(input int vld, input int r0, input int r1, input int cin,
                       input int lmin, input int lmax);
    vld_pct = vld; rdy0_pct = r0; rdy1_pct = r1; cin_pct = cin;
    lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_owner", owner, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err_orphan", err_orphan, 0);
    chk("rst_treadys", {i0_tready, i1_tready, core_out_tready}, 0);
    chk("rst_tvalids", {core_in_tvalid, o0_tvalid, o1_tvalid}, 0);

    // orphan core beat while idle
    core_auto = 1'b0;
    step(1);
    core_out_tvalid = 1'b1; core_out_tdata = 32'hdead_beef; core_out_tlast = 1'b1;
    @(negedge clk);
    chk("orphan_core_tready", core_out_tready, 0);
    chk("orphan_out_valid", {o1_tvalid, o0_tvalid}, 0);
    step(1);
    core_out_tvalid = 1'b0;
    @(negedge clk);
    chk("orphan_set", err_orphan, 1);
    step(5);
    @(negedge clk);
    chk("orphan_sticky", err_orphan, 1);
    chk("orphan_inflight", inflight, 0);
    core_auto = 1'b1;
    do_reset();
    @(negedge clk);
    chk("orphan_cleared", err_orphan, 0);

    // port0 only, 4 beats, latency 5
    knobs(100, 100, 100, 100, 5, 5);
    push_pkt(0, 4);
    wait_owner("t3_grant", 2'b01, 20);
    chk("t3_inflight_1", inflight, 1);
    wait_drain("t3_drain", 100);
    chk("t3_inflight_0", inflight, 0);
    chk("t3_o0_beats", o0_beats, 4);
    chk("t3_o1_beats", o1_beats, 0);

    // both ports continuously valid: alternate grants, one bubble, same output order
    do_reset();
    knobs(100, 100, 100, 100, 1, 3);
    for (int k = 0; k < 4; k++) begin push_pkt(0, 3); push_pkt(1, 3); end
    wait_drain("t4_drain", 300);
    chk("t4_grants", gq_port.size(), 8);
    chk("t4_outputs", oq_port.size(), 8);
    for (int k = 0; k < 8 && k < gq_port.size() && k < oq_port.size(); k++) begin
      chk($sformatf("t4_grant_port%0d", k), gq_port[k], k % 2);
      chk($sformatf("t4_out_order%0d", k), oq_port[k], gq_port[k]);
      if (k > 0) chk($sformatf("t4_grant_gap%0d", k), gq_cyc[k] - gq_cyc[k-1], 4);
    end

    // full tag FIFO with port0 results stalled
    do_reset();
    knobs(100, 0, 100, 100, 1, 2);
    for (int k = 0; k < 4; k++) begin push_pkt(0, 2); push_pkt(1, 2); end
    push_pkt(0, 2);
    step(80);
    @(negedge clk);
    chk("t5_inflight_full", inflight, 8);
    chk("t5_grants_stop", gq_port.size(), 8);
    chk("t5_owner_idle", owner, 0);
    chk("t5_pkt9_waiting", in_q0.size(), 2);
    rdy0_pct = 100;
    wait_drain("t5_drain", 300);
    chk("t5_grants_all", gq_port.size(), 9);
    chk("t5_outputs_all", oq_port.size(), 9);
    for (int k = 0; k < 9 && k < gq_port.size() && k < oq_port.size(); k++)
      chk($sformatf("t5_out_order%0d", k), oq_port[k], gq_port[k]);
    chk("t5_inflight_0", inflight, 0);

    // disabled port is never granted
    do_reset();
    knobs(100, 100, 100, 100, 1, 2);
    port_en = 2'b01;
    push_pkt(1, 2);
    step(30);
    @(negedge clk);
    chk("t6_no_grant", gq_port.size(), 0);
    chk("t6_i1_tready", i1_tready, 0);
    chk("t6_i1_pending", in_q1.size(), 2);
    step(1);
    port_en = 2'b11;
    wait_drain("t6_drain", 100);
    chk("t6_granted_later", gq_port.size(), 1);

    // clearing port_en mid-packet lets the packet finish
    do_reset();
    knobs(100, 100, 100, 100, 1, 2);
    push_pkt(0, 4);
    wait_owner("t7_grant", 2'b01, 20);
    step(1);
    port_en = 2'b10;
    wait_drain("t7_drain", 100);
    chk("t7_o0_beats", o0_beats, 4);
    push_pkt(0, 1);
    step(20);
    chk("t7_no_new_grant", in_q0.size(), 1);
    port_en = 2'b11;
    wait_drain("t7_drain2", 100);

    // reset in the middle of a packet
    do_reset();
    knobs(100, 0, 100, 100, 1, 2);
    push_pkt(0, 4);
    wait_owner("t8_grant", 2'b01, 20);
    chk("t8_inflight_pre", inflight, 1);
    step(2);
    do_reset();
    @(negedge clk);
    chk("t8_owner", owner, 0);
    chk("t8_inflight", inflight, 0);
    chk("t8_tvalids", {core_in_tvalid, o0_tvalid, o1_tvalid}, 0);
    chk("t8_treadys", {i0_tready, i1_tready}, 0);

    // randomized traffic on every interface
    do_reset();
    knobs(70, 75, 75, 70, 1, 8);
    for (int k = 0; k < 1000; k++) push_pkt($urandom_range(1), $urandom_range(4, 1));
    wait_drain("t9_drain", 60000);
    chk("t9_grants", gq_port.size(), 1000);
    chk("t9_outputs", oq_port.size(), 1000);
    for (int k = 0; k < gq_port.size() && k < oq_port.size(); k++)
      chk($sformatf("t9_out_order%0d", k), oq_port[k], gq_port[k]);
    chk("t9_inflight_0", inflight, 0);
    chk("t9_no_orphan", err_orphan, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
